// File: rtl/hex_prim_assembler.sv
// hex_prim_assembler: collects vertices three at a time into triangles
// (triangle list, no reuse). Once the third vertex arrives it computes the
// signed area, bounding box, max LOD and winding. It then hands the result
// downstream over a valid/ready handshake.
// Optional feature macro: HEX_PRIM_CULL_EN. When it is defined, triangles
// with area <= 0 are dropped and counted in cull_count.
module hex_prim_assembler #(
  parameter int COORD_W = 32,
  parameter int LOD_W   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      vtx_valid,
  output logic                      vtx_ready,
  input  logic signed [COORD_W-1:0] vtx_x,
  input  logic signed [COORD_W-1:0] vtx_y,
  input  logic [LOD_W-1:0]          vtx_lod,
  output logic                      tri_valid,
  input  logic                      tri_ready,
  output logic signed [COORD_W-1:0] tri_x0,
  output logic signed [COORD_W-1:0] tri_x1,
  output logic signed [COORD_W-1:0] tri_x2,
  output logic signed [COORD_W-1:0] tri_y0,
  output logic signed [COORD_W-1:0] tri_y1,
  output logic signed [COORD_W-1:0] tri_y2,
  output logic signed [COORD_W-1:0] bbox_xmin,
  output logic signed [COORD_W-1:0] bbox_xmax,
  output logic signed [COORD_W-1:0] bbox_ymin,
  output logic signed [COORD_W-1:0] bbox_ymax,
  output logic [LOD_W-1:0]          tri_lod,
  output logic                      tri_ccw,
  output logic [15:0]               cull_count
);

  // Edge deltas need one extra bit. Each product needs twice that width.
  // The difference of two products needs one more bit, so no overflow is possible.
  localparam int DW = COORD_W + 1;
  localparam int PW = 2 * COORD_W + 2;
  localparam int AW = 2 * COORD_W + 3;

  typedef enum logic [2:0] {
    C0   = 3'd0,
    C1   = 3'd1,
    C2   = 3'd2,
    EVAL = 3'd3,
    OUT  = 3'd4
  } state_t;

  state_t                     state_q;
  logic                       vtx_ready_q;
  logic                       tri_valid_q;
  logic signed [COORD_W-1:0]  x_q [3];
  logic signed [COORD_W-1:0]  y_q [3];
  logic [LOD_W-1:0]           lod_q [3];
  logic signed [COORD_W-1:0]  tri_x_q [3];
  logic signed [COORD_W-1:0]  tri_y_q [3];
  logic signed [COORD_W-1:0]  xmin_q, xmax_q, ymin_q, ymax_q;
  logic [LOD_W-1:0]           tri_lod_q;
  logic                       tri_ccw_q;

  logic                       hs_s;
  logic [1:0]                 slot_s;
  logic signed [DW-1:0]       dx1_s, dy2_s, dx2_s, dy1_s;
  logic signed [PW-1:0]       prod_a_s, prod_b_s;
  logic signed [AW-1:0]       area_s;
  logic                       ccw_s;

  function automatic logic signed [COORD_W-1:0] smin3(
    input logic signed [COORD_W-1:0] a,
    input logic signed [COORD_W-1:0] b,
    input logic signed [COORD_W-1:0] c);
    logic signed [COORD_W-1:0] m;
    m = (b < a) ? b : a;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [COORD_W-1:0] smax3(
    input logic signed [COORD_W-1:0] a,
    input logic signed [COORD_W-1:0] b,
    input logic signed [COORD_W-1:0] c);
    logic signed [COORD_W-1:0] m;
    m = (b > a) ? b : a;
    return (c > m) ? c : m;
  endfunction

  function automatic logic [LOD_W-1:0] umax3(
    input logic [LOD_W-1:0] a,
    input logic [LOD_W-1:0] b,
    input logic [LOD_W-1:0] c);
    logic [LOD_W-1:0] m;
    m = (b > a) ? b : a;
    return (c > m) ? c : m;
  endfunction

  // Vertex handshake and the slot that the current collect state writes
  always_comb begin
    hs_s = vtx_valid && vtx_ready_q;
    case (state_q)
      C1:      slot_s = 2'd1;
      C2:      slot_s = 2'd2;
      default: slot_s = 2'd0;
    endcase
  end

  // Full-precision signed area (twice the triangle area); positive means CCW
  always_comb begin
    dx1_s    = DW'(x_q[1]) - DW'(x_q[0]);
    dy2_s    = DW'(y_q[2]) - DW'(y_q[0]);
    dx2_s    = DW'(x_q[2]) - DW'(x_q[0]);
    dy1_s    = DW'(y_q[1]) - DW'(y_q[0]);
    prod_a_s = PW'(dx1_s) * PW'(dy2_s);
    prod_b_s = PW'(dx2_s) * PW'(dy1_s);
    area_s   = AW'(prod_a_s) - AW'(prod_b_s);
    ccw_s    = !area_s[AW-1] && (area_s != {AW{1'b0}});
  end

`ifdef HEX_PRIM_CULL_EN
  logic [15:0] cull_q;
  assign cull_count = cull_q;
`else
  assign cull_count = 16'h0000;
`endif

  // Collect/evaluate/output FSM with vertex slots and registered results
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= C0;
      vtx_ready_q <= 1'b0;
      tri_valid_q <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        x_q[i]     <= {COORD_W{1'b0}};
        y_q[i]     <= {COORD_W{1'b0}};
        lod_q[i]   <= {LOD_W{1'b0}};
        tri_x_q[i] <= {COORD_W{1'b0}};
        tri_y_q[i] <= {COORD_W{1'b0}};
      end
      xmin_q    <= {COORD_W{1'b0}};
      xmax_q    <= {COORD_W{1'b0}};
      ymin_q    <= {COORD_W{1'b0}};
      ymax_q    <= {COORD_W{1'b0}};
      tri_lod_q <= {LOD_W{1'b0}};
      tri_ccw_q <= 1'b0;
`ifdef HEX_PRIM_CULL_EN
      cull_q    <= 16'h0000;
`endif
    end else begin
      case (state_q)
        C0, C1, C2: begin
          if (hs_s) begin
            x_q[slot_s]   <= vtx_x;
            y_q[slot_s]   <= vtx_y;
            lod_q[slot_s] <= vtx_lod;
            if (state_q == C0) begin
              state_q <= C1;
            end else if (state_q == C1) begin
              state_q <= C2;
            end else begin
              state_q <= EVAL;
            end
            vtx_ready_q <= (state_q != C2);
          end else begin
            vtx_ready_q <= 1'b1;
          end
        end
        EVAL: begin
          for (int i = 0; i < 3; i++) begin
            tri_x_q[i] <= x_q[i];
            tri_y_q[i] <= y_q[i];
          end
          xmin_q    <= smin3(x_q[0], x_q[1], x_q[2]);
          xmax_q    <= smax3(x_q[0], x_q[1], x_q[2]);
          ymin_q    <= smin3(y_q[0], y_q[1], y_q[2]);
          ymax_q    <= smax3(y_q[0], y_q[1], y_q[2]);
          tri_lod_q <= umax3(lod_q[0], lod_q[1], lod_q[2]);
          tri_ccw_q <= ccw_s;
`ifdef HEX_PRIM_CULL_EN
          if (!ccw_s) begin
            state_q     <= C0;
            vtx_ready_q <= 1'b1;
            if (cull_q != 16'hFFFF) begin
              cull_q <= cull_q + 16'h0001;
            end else begin
              cull_q <= cull_q;
            end
          end else begin
            state_q <= OUT;
          end
`else
          state_q <= OUT;
`endif
        end
        OUT: begin
          // tri_valid rises one cycle after entering OUT
          if (tri_valid_q && tri_ready) begin
            state_q     <= C0;
            tri_valid_q <= 1'b0;
            vtx_ready_q <= 1'b1;
          end else begin
            tri_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= C0;
          tri_valid_q <= 1'b0;
          vtx_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign vtx_ready = vtx_ready_q;
  assign tri_valid = tri_valid_q;
  assign tri_x0    = tri_x_q[0];
  assign tri_x1    = tri_x_q[1];
  assign tri_x2    = tri_x_q[2];
  assign tri_y0    = tri_y_q[0];
  assign tri_y1    = tri_y_q[1];
  assign tri_y2    = tri_y_q[2];
  assign bbox_xmin = xmin_q;
  assign bbox_xmax = xmax_q;
  assign bbox_ymin = ymin_q;
  assign bbox_ymax = ymax_q;
  assign tri_lod   = tri_lod_q;
  assign tri_ccw   = tri_ccw_q;

endmodule
